// File: rtl/rgen_host_if_axi4lite.sv
// AXI4-Lite slave host interface for generated register blocks.
// Converts one AXI4-Lite transaction at a time into the local command bus and
// returns the response mux result on B/R. AW, W and AR are captured into
// single-entry holding registers; a write/read priority pointer gives fairness.
// Optional build macro: RGEN_AXI4LITE_DECERR_EN (decode miss reports DECERR).
module rgen_host_if_axi4lite #(
   parameter int unsigned DATA_WIDTH          = 32,
   parameter int unsigned HOST_ADDRESS_WIDTH  = 16,
   parameter int unsigned LOCAL_ADDRESS_WIDTH = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   // Write address channel
   input  logic                           i_awvalid,
   output logic                           o_awready,
   input  logic [HOST_ADDRESS_WIDTH-1:0]  i_awaddr,
   input  logic [2:0]                     i_awprot,
   // Write data channel
   input  logic                           i_wvalid,
   output logic                           o_wready,
   input  logic [DATA_WIDTH-1:0]          i_wdata,
   input  logic [DATA_WIDTH/8-1:0]        i_wstrb,
   // Write response channel
   output logic                           o_bvalid,
   input  logic                           i_bready,
   output logic [1:0]                     o_bresp,
   // Read address channel
   input  logic                           i_arvalid,
   output logic                           o_arready,
   input  logic [HOST_ADDRESS_WIDTH-1:0]  i_araddr,
   input  logic [2:0]                     i_arprot,
   // Read data channel
   output logic                           o_rvalid,
   input  logic                           i_rready,
   output logic [DATA_WIDTH-1:0]          o_rdata,
   output logic [1:0]                     o_rresp,
   // Local command bus
   output logic                           o_command_valid,
   output logic                           o_write,
   output logic                           o_read,
   output logic [LOCAL_ADDRESS_WIDTH-1:0] o_address,
   output logic [DATA_WIDTH-1:0]          o_write_data,
   output logic [DATA_WIDTH-1:0]          o_write_mask,
   input  logic                           i_response_ready,
   input  logic [DATA_WIDTH-1:0]          i_read_data,
   input  logic [2:0]                     i_status
);

   localparam int unsigned StrbWidth = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      StIdle,
      StCommand,
      StWaitB,
      StWaitR
   } state_e;

   state_e                         state_q, state_d;
   logic                           aw_held_q, aw_held_d;
   logic                           w_held_q, w_held_d;
   logic                           ar_held_q, ar_held_d;
   logic [LOCAL_ADDRESS_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [LOCAL_ADDRESS_WIDTH-1:0] araddr_q, araddr_d;
   logic [DATA_WIDTH-1:0]          wdata_q, wdata_d;
   logic [StrbWidth-1:0]           wstrb_q, wstrb_d;
   // 1: the most recent grant was a write, so a contending read wins next
   logic                           last_write_q, last_write_d;

   logic                           cmd_valid_q, cmd_valid_d;
   logic                           cmd_write_q, cmd_write_d;
   logic                           cmd_read_q, cmd_read_d;
   logic [LOCAL_ADDRESS_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
   logic [DATA_WIDTH-1:0]          cmd_wdata_q, cmd_wdata_d;
   logic [DATA_WIDTH-1:0]          cmd_mask_q, cmd_mask_d;

   logic                           bvalid_q, bvalid_d;
   logic [1:0]                     bresp_q, bresp_d;
   logic                           rvalid_q, rvalid_d;
   logic [1:0]                     rresp_q, rresp_d;
   logic [DATA_WIDTH-1:0]          rdata_q, rdata_d;

   logic                           is_idle;
   logic                           awready, wready, arready;
   logic                           aw_hs, w_hs, ar_hs;
   logic                           wr_rdy, rd_rdy, grant_wr, grant_rd;
   logic [LOCAL_ADDRESS_WIDTH-1:0] aw_addr_eff, ar_addr_eff;
   logic [DATA_WIDTH-1:0]          w_data_eff;
   logic [StrbWidth-1:0]           w_strb_eff;
   logic [DATA_WIDTH-1:0]          w_mask_eff;
   logic [1:0]                     resp_map;

   // Protection bits, status bit2 and host address bits above the local window are ignored
   logic                           unused_inputs;
   assign unused_inputs = ^{i_awprot, i_arprot, i_status[2], i_awaddr, i_araddr};

   // Channel readies and handshakes; readies exist only in IDLE and never during reset
   always_comb begin
      is_idle = (state_q == StIdle);
      awready = is_idle && !aw_held_q && !rst;
      wready  = is_idle && !w_held_q && !rst;
      arready = is_idle && !ar_held_q && !rst;
      aw_hs   = i_awvalid && awready;
      w_hs    = i_wvalid && wready;
      ar_hs   = i_arvalid && arready;
   end

   // Request selection: held copy if present, otherwise the same-cycle bus value
   always_comb begin
      aw_addr_eff = aw_held_q ? awaddr_q : i_awaddr[LOCAL_ADDRESS_WIDTH-1:0];
      ar_addr_eff = ar_held_q ? araddr_q : i_araddr[LOCAL_ADDRESS_WIDTH-1:0];
      w_data_eff  = w_held_q ? wdata_q : i_wdata;
      w_strb_eff  = w_held_q ? wstrb_q : i_wstrb;
      w_mask_eff  = '0;
      for (int i = 0; i < StrbWidth; i++) begin
         w_mask_eff[i*8 +: 8] = {8{w_strb_eff[i]}};
      end
   end

   // Arbitration: a read beats a contending write only right after a write grant
   always_comb begin
      wr_rdy   = (aw_held_q || aw_hs) && (w_held_q || w_hs);
      rd_rdy   = ar_held_q || ar_hs;
      grant_rd = is_idle && rd_rdy && (!wr_rdy || last_write_q);
      grant_wr = is_idle && wr_rdy && !grant_rd;
   end

   // Status to AXI response code
   always_comb begin
      resp_map = 2'b00;
`ifdef RGEN_AXI4LITE_DECERR_EN
      if (i_status[1]) begin
         resp_map = 2'b11;
      end else if (i_status[0]) begin
         resp_map = 2'b10;
      end
`else
      if (i_status[1:0] != 2'b00) begin
         resp_map = 2'b10;
      end
`endif
   end

   // Next-state logic for the transaction FSM, holding registers and outputs
   always_comb begin
      state_d      = state_q;
      aw_held_d    = aw_held_q | aw_hs;
      w_held_d     = w_held_q | w_hs;
      ar_held_d    = ar_held_q | ar_hs;
      awaddr_d     = aw_hs ? i_awaddr[LOCAL_ADDRESS_WIDTH-1:0] : awaddr_q;
      araddr_d     = ar_hs ? i_araddr[LOCAL_ADDRESS_WIDTH-1:0] : araddr_q;
      wdata_d      = w_hs ? i_wdata : wdata_q;
      wstrb_d      = w_hs ? i_wstrb : wstrb_q;
      last_write_d = last_write_q;
      cmd_valid_d  = cmd_valid_q;
      cmd_write_d  = cmd_write_q;
      cmd_read_d   = cmd_read_q;
      cmd_addr_d   = cmd_addr_q;
      cmd_wdata_d  = cmd_wdata_q;
      cmd_mask_d   = cmd_mask_q;
      bvalid_d     = bvalid_q;
      bresp_d      = bresp_q;
      rvalid_d     = rvalid_q;
      rresp_d      = rresp_q;
      rdata_d      = rdata_q;

      case (state_q)
         StIdle: begin
            if (grant_wr) begin
               cmd_valid_d  = 1'b1;
               cmd_write_d  = 1'b1;
               cmd_read_d   = 1'b0;
               cmd_addr_d   = aw_addr_eff;
               cmd_wdata_d  = w_data_eff;
               cmd_mask_d   = w_mask_eff;
               last_write_d = 1'b1;
               state_d      = StCommand;
            end else if (grant_rd) begin
               cmd_valid_d  = 1'b1;
               cmd_write_d  = 1'b0;
               cmd_read_d   = 1'b1;
               cmd_addr_d   = ar_addr_eff;
               cmd_wdata_d  = '0;
               cmd_mask_d   = '0;
               last_write_d = 1'b0;
               state_d      = StCommand;
            end
         end
         StCommand: begin
            if (i_response_ready) begin
               cmd_valid_d = 1'b0;
               cmd_write_d = 1'b0;
               cmd_read_d  = 1'b0;
               if (cmd_write_q) begin
                  bvalid_d  = 1'b1;
                  bresp_d   = resp_map;
                  aw_held_d = 1'b0;
                  w_held_d  = 1'b0;
                  state_d   = StWaitB;
               end else begin
                  rvalid_d  = 1'b1;
                  rresp_d   = resp_map;
                  rdata_d   = i_read_data;
                  ar_held_d = 1'b0;
                  state_d   = StWaitR;
               end
            end
         end
         StWaitB: begin
            if (i_bready) begin
               bvalid_d = 1'b0;
               bresp_d  = 2'b00;
               state_d  = StIdle;
            end
         end
         StWaitR: begin
            if (i_rready) begin
               rvalid_d = 1'b0;
               rresp_d  = 2'b00;
               rdata_d  = '0;
               state_d  = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State registers; reset drops any transaction in flight without a response
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         aw_held_q    <= 1'b0;
         w_held_q     <= 1'b0;
         ar_held_q    <= 1'b0;
         awaddr_q     <= '0;
         araddr_q     <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         last_write_q <= 1'b0;
         cmd_valid_q  <= 1'b0;
         cmd_write_q  <= 1'b0;
         cmd_read_q   <= 1'b0;
         cmd_addr_q   <= '0;
         cmd_wdata_q  <= '0;
         cmd_mask_q   <= '0;
         bvalid_q     <= 1'b0;
         bresp_q      <= 2'b00;
         rvalid_q     <= 1'b0;
         rresp_q      <= 2'b00;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         aw_held_q    <= aw_held_d;
         w_held_q     <= w_held_d;
         ar_held_q    <= ar_held_d;
         awaddr_q     <= awaddr_d;
         araddr_q     <= araddr_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         last_write_q <= last_write_d;
         cmd_valid_q  <= cmd_valid_d;
         cmd_write_q  <= cmd_write_d;
         cmd_read_q   <= cmd_read_d;
         cmd_addr_q   <= cmd_addr_d;
         cmd_wdata_q  <= cmd_wdata_d;
         cmd_mask_q   <= cmd_mask_d;
         bvalid_q     <= bvalid_d;
         bresp_q      <= bresp_d;
         rvalid_q     <= rvalid_d;
         rresp_q      <= rresp_d;
         rdata_q      <= rdata_d;
      end
   end

   assign o_awready       = awready;
   assign o_wready        = wready;
   assign o_arready       = arready;
   assign o_bvalid        = bvalid_q;
   assign o_bresp         = bresp_q;
   assign o_rvalid        = rvalid_q;
   assign o_rresp         = rresp_q;
   assign o_rdata         = rdata_q;
   assign o_command_valid = cmd_valid_q;
   assign o_write         = cmd_write_q;
   assign o_read          = cmd_read_q;
   assign o_address       = cmd_addr_q;
   assign o_write_data    = cmd_wdata_q;
   assign o_write_mask    = cmd_mask_q;

endmodule

// File: tb/tb_rgen_host_if_axi4lite.sv
// Directed testbench for rgen_host_if_axi4lite with a command/response scoreboard.
module tb_rgen_host_if_axi4lite;

   logic        clk;
   logic        rst;
   logic        i_awvalid, o_awready;
   logic [15:0] i_awaddr;
   logic [2:0]  i_awprot;
   logic        i_wvalid, o_wready;
   logic [31:0] i_wdata;
   logic [3:0]  i_wstrb;
   logic        o_bvalid, i_bready;
   logic [1:0]  o_bresp;
   logic        i_arvalid, o_arready;
   logic [15:0] i_araddr;
   logic [2:0]  i_arprot;
   logic        o_rvalid, i_rready;
   logic [31:0] o_rdata;
   logic [1:0]  o_rresp;
   logic        o_command_valid, o_write, o_read;
   logic [7:0]  o_address;
   logic [31:0] o_write_data, o_write_mask;
   logic        i_response_ready;
   logic [31:0] i_read_data;
   logic [2:0]  i_status;

   typedef struct packed {
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] data;
      logic [31:0] mask;
   } cmd_t;

   typedef struct packed {
      logic        wr;
      logic [1:0]  resp;
      logic [31:0] rdata;
   } rsp_t;

   cmd_t cmd_q[$];
   rsp_t rsp_q[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   rgen_host_if_axi4lite dut (
      .clk              (clk),
      .rst              (rst),
      .i_awvalid        (i_awvalid),
      .o_awready        (o_awready),
      .i_awaddr         (i_awaddr),
      .i_awprot         (i_awprot),
      .i_wvalid         (i_wvalid),
      .o_wready         (o_wready),
      .i_wdata          (i_wdata),
      .i_wstrb          (i_wstrb),
      .o_bvalid         (o_bvalid),
      .i_bready         (i_bready),
      .o_bresp          (o_bresp),
      .i_arvalid        (i_arvalid),
      .o_arready        (o_arready),
      .i_araddr         (i_araddr),
      .i_arprot         (i_arprot),
      .o_rvalid         (o_rvalid),
      .i_rready         (i_rready),
      .o_rdata          (o_rdata),
      .o_rresp          (o_rresp),
      .o_command_valid  (o_command_valid),
      .o_write          (o_write),
      .o_read           (o_read),
      .o_address        (o_address),
      .o_write_data     (o_write_data),
      .o_write_mask     (o_write_mask),
      .i_response_ready (i_response_ready),
      .i_read_data      (i_read_data),
      .i_status         (i_status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something escapes the per-wait bounds
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [1:0] exp_resp(input logic [2:0] st);
`ifdef RGEN_AXI4LITE_DECERR_EN
      if (st[1]) return 2'b11;
`endif
      if (st[1:0] != 2'b00) return 2'b10;
      return 2'b00;
   endfunction

   task automatic push_cmd(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                           input logic [31:0] mask);
      cmd_t c;
      c.wr = wr; c.addr = addr; c.data = data; c.mask = mask;
      cmd_q.push_back(c);
   endtask

   // Present the selected requests and drop each valid once its handshake has happened
   task automatic issue(input bit do_aw, input bit do_w, input bit do_ar,
                        input logic [15:0] waddr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic [15:0] raddr);
      logic a, w, r;
      int   n;
      i_awvalid = do_aw; i_awaddr = waddr;
      i_wvalid  = do_w;  i_wdata  = wdata; i_wstrb = wstrb;
      i_arvalid = do_ar; i_araddr = raddr;
      n = 0;
      while ((i_awvalid || i_wvalid || i_arvalid) && n < 20) begin
         #1;
         a = o_awready; w = o_wready; r = o_arready;
         tick();
         if (a) i_awvalid = 1'b0;
         if (w) i_wvalid  = 1'b0;
         if (r) i_arvalid = 1'b0;
         n++;
      end
      check("req_handshake", {i_awvalid, i_wvalid, i_arvalid}, 3'b000);
      i_awvalid = 1'b0; i_wvalid = 1'b0; i_arvalid = 1'b0;
   endtask

   // Act as the response mux for the next command
   task automatic serve(input int max_wait, input int delay, input logic [2:0] st,
                        input logic [31:0] rd);
      cmd_t e;
      rsp_t r;
      int   n;
      n = 0;
      while (!o_command_valid && n < max_wait) begin
         tick();
         n++;
      end
      check("cmd_valid", o_command_valid, 1'b1);
      e = (cmd_q.size() > 0) ? cmd_q.pop_front() : '0;
      check("cmd_write", o_write, e.wr);
      check("cmd_read", o_read, !e.wr);
      check("cmd_address", o_address, e.addr);
      if (e.wr) begin
         check("cmd_wdata", o_write_data, e.data);
         check("cmd_wmask", o_write_mask, e.mask);
      end
      for (int i = 0; i < delay; i++) begin
         tick();
         check("cmd_hold_valid", o_command_valid, 1'b1);
         check("cmd_hold_addr", o_address, e.addr);
      end
      i_response_ready = 1'b1; i_status = st; i_read_data = rd;
      r.wr = e.wr; r.resp = exp_resp(st); r.rdata = rd;
      rsp_q.push_back(r);
      tick();
      i_response_ready = 1'b0; i_status = 3'b000; i_read_data = $urandom;
      check("cmd_done", o_command_valid, 1'b0);
   endtask

   // Collect the next B/R response, optionally stalling the host for some cycles
   task automatic collect(input int hold);
      rsp_t e;
      int   n;
      n = 0;
      while (!(o_bvalid || o_rvalid) && n < 10) begin
         tick();
         n++;
      end
      e = (rsp_q.size() > 0) ? rsp_q.pop_front() : '0;
      for (int i = 0; i <= hold; i++) begin
         if (i > 0) tick();
         if (e.wr) begin
            check("bvalid", o_bvalid, 1'b1);
            check("bresp", o_bresp, e.resp);
            check("no_rvalid", o_rvalid, 1'b0);
         end else begin
            check("rvalid", o_rvalid, 1'b1);
            check("rresp", o_rresp, e.resp);
            check("rdata", o_rdata, e.rdata);
            check("no_bvalid", o_bvalid, 1'b0);
         end
         check("arready_pending", o_arready, 1'b0);
      end
      if (e.wr) i_bready = 1'b1; else i_rready = 1'b1;
      tick();
      i_bready = 1'b0; i_rready = 1'b0;
      check("resp_released", {o_bvalid, o_rvalid}, 2'b00);
   endtask

   initial begin
      rst = 1'b1;
      i_awvalid = 0; i_awaddr = 0; i_awprot = 3'b010;
      i_wvalid = 0; i_wdata = 0; i_wstrb = 0; i_bready = 0;
      i_arvalid = 0; i_araddr = 0; i_arprot = 3'b001; i_rready = 0;
      i_response_ready = 0; i_read_data = 0; i_status = 0;
      repeat (3) tick();
      check("rst_readies", {o_awready, o_wready, o_arready}, 3'b000);
      check("rst_valids", {o_command_valid, o_bvalid, o_rvalid}, 3'b000);
      check("rst_cmd", {o_write, o_read, o_address}, 10'h0);
      rst = 1'b0;
      #1;
      check("idle_readies", {o_awready, o_wready, o_arready}, 3'b111);

      // AW+W together: command one cycle later, low two bytes enabled
      push_cmd(1'b1, 8'h04, 32'hDEAD_BEEF, 32'h0000_FFFF);
      issue(1, 1, 0, 16'h0004, 32'hDEAD_BEEF, 4'h3, 16'h0);
      serve(0, 0, 3'b000, 32'hAAAA_5555);
      collect(0);

      // W well before AW: nothing issued until AW arrives, W channel blocked meanwhile
      push_cmd(1'b1, 8'h0C, 32'hCAFE_F00D, 32'hFFFF_FFFF);
      issue(0, 1, 0, 16'h0, 32'hCAFE_F00D, 4'hF, 16'h0);
      for (int i = 0; i < 3; i++) begin
         check("w_held_wready", o_wready, 1'b0);
         check("w_only_no_cmd", o_command_valid, 1'b0);
         tick();
      end
      issue(1, 0, 0, 16'h000C, 32'h0, 4'h0, 16'h0);
      serve(0, 2, 3'b000, 32'h0);
      collect(0);

      // Read with a host stall on R
      push_cmd(1'b0, 8'h08, 32'h0, 32'h0);
      issue(0, 0, 1, 16'h0, 32'h0, 4'h0, 16'h0008);
      serve(0, 0, 3'b000, 32'h1234_5678);
      collect(5);

      // Upper host address bits dropped, sparse strobes
      push_cmd(1'b1, 8'h10, 32'h1122_3344, 32'hFF00_FF00);
      issue(1, 1, 0, 16'hAB10, 32'h1122_3344, 4'b1010, 16'h0);
      serve(0, 0, 3'b000, 32'h0);
      collect(0);

      // Contention after a write: read first, then the held write
      push_cmd(1'b0, 8'h20, 32'h0, 32'h0);
      push_cmd(1'b1, 8'h24, 32'h55AA_55AA, 32'hFFFF_FFFF);
      issue(1, 1, 1, 16'h0024, 32'h55AA_55AA, 4'hF, 16'h0020);
      serve(0, 0, 3'b000, 32'hA5A5_0001);
      collect(0);
      serve(5, 0, 3'b000, 32'h0);
      collect(0);

      // Lone read (status bit2 is ignored), making the last grant a read
      push_cmd(1'b0, 8'h30, 32'h0, 32'h0);
      issue(0, 0, 1, 16'h0, 32'h0, 4'h0, 16'h0030);
      serve(0, 0, 3'b100, 32'h0BAD_F00D);
      collect(0);

      // Contention after a read: write first, then the held read; error responses
      push_cmd(1'b1, 8'h40, 32'h0F0F_0F0F, 32'h0000_00FF);
      push_cmd(1'b0, 8'h44, 32'h0, 32'h0);
      issue(1, 1, 1, 16'h0040, 32'h0F0F_0F0F, 4'h1, 16'h0044);
      serve(0, 0, 3'b001, 32'h0);
      collect(0);
      serve(5, 0, 3'b010, 32'h1357_9BDF);
      collect(1);

      // Decode miss on a write, both error bits on a read
      push_cmd(1'b1, 8'h50, 32'h7777_8888, 32'hFFFF_0000);
      issue(1, 1, 0, 16'h0050, 32'h7777_8888, 4'hC, 16'h0);
      serve(0, 0, 3'b010, 32'h0);
      collect(0);
      push_cmd(1'b0, 8'h54, 32'h0, 32'h0);
      issue(0, 0, 1, 16'h0, 32'h0, 4'h0, 16'h0054);
      serve(0, 0, 3'b011, 32'hFEED_FACE);
      collect(0);

      // Reset while a command is active: dropped without any response
      issue(1, 1, 0, 16'h0060, 32'h9999_9999, 4'hF, 16'h0);
      check("pre_rst_cmd", o_command_valid, 1'b1);
      rst = 1'b1;
      tick();
      check("mid_rst_valids", {o_command_valid, o_bvalid, o_rvalid}, 3'b000);
      check("mid_rst_readies", {o_awready, o_wready, o_arready}, 3'b000);
      rst = 1'b0;
      tick();
      check("post_rst_valids", {o_command_valid, o_bvalid, o_rvalid}, 3'b000);

      // Fresh write after reset
      push_cmd(1'b1, 8'h64, 32'h0123_4567, 32'hFFFF_FFFF);
      issue(1, 1, 0, 16'h0064, 32'h0123_4567, 4'hF, 16'h0);
      serve(0, 1, 3'b000, 32'h0);
      collect(0);

      check("cmd_queue_drained", cmd_q.size(), 0);
      check("rsp_queue_drained", rsp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
